uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters.
//  Sits between client logic and the TxUnit inside the duplex UART top.
//  Grants one requester, drives the transmitter's send/data_in, then waits for its done flag.
//  Only after that does it move on to the next requester.
// PARAMETERS
//  NUM_REQ        4     number of requesters (2..16)
//  DATA_W         8     byte width; matches transmitter data_in
//  GAP_CYCLES     2     idle clocks forced between frames (>=1)
//  TIMEOUT_CYCLES 65535 max clocks from send to done before abort (UART_ARB_TIMEOUT_EN only)
// PORTS
//  clock          in   1               system clock, all logic on rising edge
//  reset          in   1               synchronous, active-high reset
//  req_valid      in   NUM_REQ         requester i has a byte pending; held until its req_ready
//  req_data       in   NUM_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W]
//  req_ready      out  NUM_REQ         one-cycle pulse: byte of requester i captured
//  grant_id       out  clog2(NUM_REQ)  index of requester being served (valid while busy)
//  busy           out  1               high from capture until GAP completes
//  uart_send      out  1               to transmitter send
//  uart_data      out  DATA_W          to transmitter data_in; stable while busy
//  uart_tx_active in   1               transmitter active_flag
//  uart_tx_done   in   1               transmitter done_flag
//  timeout_err    out  1               one-cycle pulse on abort; constant 0 without macro
// BEHAVIOUR
//  Reset: state IDLE, req_ready=0, grant_id=0, busy=0, uart_send=0, uart_data=0, timeout_err=0.
//  Reset: rr pointer=0 (requester 0 has highest priority first). Reset mid-frame aborts immediately.
//  Reset mid-frame: no req_ready or timeout_err is issued.
//  FSM IDLE -> SEND -> WAIT_DONE -> GAP -> IDLE.
//  IDLE: if any req_valid, grant the first set bit at/after pointer, wrapping NUM_REQ-1 -> 0.
//   On the same edge: capture req_data of the winner into uart_data and set grant_id.
//   Also on that edge: busy=1, uart_send=1, req_ready[winner]=1 for exactly the next cycle.
//   Pointer := winner+1 mod NUM_REQ. None valid: stay IDLE, outputs unchanged.
//  SEND: uart_send held high until uart_tx_active=1 is sampled.
//   Then uart_send=0 and go to WAIT_DONE; that edge can be the first SEND cycle.
//   uart_tx_done sampled in SEND (frame finished before active seen) -> treat as done, go GAP.
//  WAIT_DONE: on uart_tx_done=1 go to GAP, reload gap counter with GAP_CYCLES-1.
//  GAP: uart_send=0, busy=1; count down to 0, then IDLE and busy=0.
//   Requests arriving in GAP wait; no grant is issued in GAP.
//  Latency: req_valid sampled in IDLE -> uart_send high and req_ready pulse the following cycle.
//  Requester dropping req_valid before grant: simply not considered; no error.
//  req_valid changing during busy: ignored until next IDLE.
//  Fairness: a requester waits at most NUM_REQ-1 frames.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: a cycle counter runs in SEND and WAIT_DONE, cleared on entry to SEND.
//   Reaching TIMEOUT_CYCLES without done: uart_send=0, timeout_err pulses 1 cycle, go to GAP.
//   The pointer has already advanced, so the next requester is served next.
//  Not defined: no counter logic; timeout_err tied 0; SEND/WAIT_DONE wait indefinitely.
// STRUCTURE
//  Shared package uart_ctrl_pkg: state enum {IDLE,SEND,WAIT_DONE,GAP}, DATA_W default,
//   and a clog2-based index width helper.
//  One sub-module rr_arbiter: pure combinational.
//   Inputs: req vector and pointer. Outputs: one-hot grant, encoded index, any_req.
//  Top holds FSM, data/grant registers, gap counter and optional timeout counter.
// TESTING
//  Single request: req_valid=4'b0100, data 8'hA5.
//   -> next cycle req_ready=4'b0100, uart_data=A5, grant_id=2, uart_send=1.
//   -> send drops the cycle after active; busy clears GAP_CYCLES after done.
//  All four valid continuously, pointer 0 -> grants 0,1,2,3,0; each captured byte matches its requester.
//  Wrap priority: pointer=3, req_valid=4'b1001 -> grant 3, then 0 (not 0 twice).
//  Late request during WAIT_DONE of req 1: not granted until GAP ends; then served ahead of req 0.
//  reset=1 in WAIT_DONE -> next cycle all outputs at reset values; a new request is then granted from 0.
//  With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20, uart_tx_done never asserted:
//   -> timeout_err pulse 20 cycles after send; next request is still served.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART control slice: arbiter FSM states,
// default byte width and an index-width helper.
package uart_ctrl_pkg;

  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    GAP
  } arb_state_e;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IW-1:0]      idx_c,
  output logic               any_c
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    cand    = '0;
    any_c   = |req;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(ptr, k);
      if (!found && req[cand]) begin
        found          = 1'b1;
        idx_c          = cand;
        grant_c[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources.
// Optional send-to-done watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned GAP_CYCLES = 2
`ifdef UART_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [idx_w(NUM_REQ)-1:0]   grant_id,
  output logic                        busy,
  output logic                        uart_send,
  output logic [DATA_W-1:0]           uart_data,
  input  logic                        uart_tx_active,
  input  logic                        uart_tx_done,
  output logic                        timeout_err
);

  localparam int unsigned IW = idx_w(NUM_REQ);
  localparam int unsigned GW = idx_w(GAP_CYCLES);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       grant_d;
  logic [DATA_W-1:0]   data_d;
  logic                busy_d;
  logic                send_d;
  logic [NUM_REQ-1:0]  ready_d;
  logic [GW-1:0]       gap_q, gap_d;

  logic [NUM_REQ-1:0]  win_onehot;
  logic [IW-1:0]       win_idx;
  logic                any_req;
  logic [DATA_W-1:0]   data_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .grant_c (win_onehot),
    .idx_c   (win_idx),
    .any_c   (any_req)
  );

  // Byte of the current round-robin winner.
  always_comb begin
    data_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) data_sel = req_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TW = idx_w(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          terr_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_id;
    data_d  = uart_data;
    busy_d  = busy;
    send_d  = uart_send;
    ready_d = '0;
    gap_d   = gap_q;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_d   = tmo_q;
    terr_d  = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = SEND;
          ptr_d   = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
          grant_d = win_idx;
          data_d  = data_sel;
          busy_d  = 1'b1;
          send_d  = 1'b1;
          ready_d = win_onehot;
`ifdef UART_ARB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      SEND: begin
        // A frame can complete before active is ever observed.
        if (uart_tx_done) begin
          state_d = GAP;
          send_d  = 1'b0;
          gap_d   = GW'(GAP_CYCLES - 1);
        end else if (uart_tx_active) begin
          state_d = WAIT_DONE;
          send_d  = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (uart_tx_done) begin
          state_d = GAP;
          gap_d   = GW'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
    endcase

`ifdef UART_ARB_TIMEOUT_EN
    // Abort a frame whose done never arrives; the pointer has already moved on.
    if ((state_q == SEND || state_q == WAIT_DONE) && !uart_tx_done) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = GAP;
        send_d  = 1'b0;
        gap_d   = GW'(GAP_CYCLES - 1);
        terr_d  = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_id  <= '0;
      uart_data <= '0;
      busy      <= 1'b0;
      uart_send <= 1'b0;
      req_ready <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_id  <= grant_d;
      uart_data <= data_d;
      busy      <= busy_d;
      uart_send <= send_d;
      req_ready <= ready_d;
      gap_q     <= gap_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_q       <= tmo_d;
      timeout_err <= terr_d;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a cycle-level reference model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 2;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMO = 20;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        uart_send;
  logic [7:0]  uart_data;
  logic        uart_tx_active;
  logic        uart_tx_done;
  logic        timeout_err;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .DATA_W(8),
    .GAP_CYCLES(GAP)
`ifdef UART_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .grant_id       (grant_id),
    .busy           (busy),
    .uart_send      (uart_send),
    .uart_data      (uart_data),
    .uart_tx_active (uart_tx_active),
    .uart_tx_done   (uart_tx_done),
    .timeout_err    (timeout_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: frame phase 0=free, 1=frame in flight, 2=inter-frame gap.
  int         m_ptr, m_phase, m_gap_left, m_elapsed;
  logic [3:0] e_ready;
  int         e_grant;
  logic       e_busy, e_send, e_terr;
  logic [7:0] e_data;

  // Transmitter stand-in.
  int tx_st, tx_timer;
  bit tx_hold, tx_fast_ok, tx_fast;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          grant;
    logic [7:0]  byte_v;
  } vec_t;
  vec_t vec[8];

  logic [7:0] q[4][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait expired at %0t", name, $time);
  endtask

  task automatic model_edge();
    int win;
    e_ready = '0;
    e_terr  = 1'b0;
    if (reset) begin
      m_ptr = 0; m_phase = 0; e_grant = 0; e_busy = 0; e_send = 0; e_data = '0;
      return;
    end
    case (m_phase)
      0: if (req_valid != 4'b0) begin
        win = -1;
        for (int k = 0; k < N; k++)
          if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        e_ready   = 4'(1 << win);
        e_grant   = win;
        e_data    = req_data[win*8 +: 8];
        e_busy    = 1'b1;
        e_send    = 1'b1;
        m_ptr     = (win + 1) % N;
        m_phase   = 1;
        m_elapsed = 0;
      end
      1: if (uart_tx_done) begin
        e_send = 1'b0; m_phase = 2; m_gap_left = GAP;
      end else begin
`ifdef UART_ARB_TIMEOUT_EN
        if (m_elapsed == TMO - 1) begin
          e_send = 1'b0; e_terr = 1'b1; m_phase = 2; m_gap_left = GAP;
        end else m_elapsed++;
`endif
        if (m_phase == 1 && e_send && uart_tx_active) e_send = 1'b0;
      end
      default: begin
        m_gap_left--;
        if (m_gap_left == 0) begin e_busy = 1'b0; m_phase = 0; end
      end
    endcase
  endtask

  task automatic drive_tx();
    uart_tx_done = 1'b0;
    if (reset || tx_hold) begin
      uart_tx_active = 1'b0; tx_st = 0;
      return;
    end
    if (tx_st == 0 && uart_send) begin
      tx_timer = $urandom_range(0, 2);
      tx_fast  = tx_fast_ok && ($urandom_range(0, 7) == 0);
      tx_st    = 1;
    end
    if (tx_st == 1) begin
      if (tx_timer == 0) begin
        if (tx_fast) begin uart_tx_done = 1'b1; tx_st = 3; end
        else begin uart_tx_active = 1'b1; tx_timer = $urandom_range(1, 5); tx_st = 2; end
      end else tx_timer--;
    end else if (tx_st == 2) begin
      if (tx_timer == 0) begin uart_tx_active = 1'b0; uart_tx_done = 1'b1; tx_st = 3; end
      else tx_timer--;
    end else if (tx_st == 3) begin
      tx_st = 0;
    end
  endtask

  task automatic check_all();
    chk("req_ready",   32'(req_ready),   32'(e_ready));
    chk("grant_id",    32'(grant_id),    32'(e_grant));
    chk("busy",        32'(busy),        32'(e_busy));
    chk("uart_send",   32'(uart_send),   32'(e_send));
    chk("uart_data",   32'(uart_data),   32'(e_data));
    chk("timeout_err", 32'(timeout_err), 32'(e_terr));
  endtask

  task automatic step();
    drive_tx();
    model_edge();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic wait_ready(input string name);
    for (int c = 0; c < 80; c++) begin
      step();
      if (req_ready != 4'b0) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 80; c++) begin
      step();
      if (!busy) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_in_frame(input string name);
    for (int c = 0; c < 40; c++) begin
      step();
      if (uart_tx_active && !uart_send) return;
    end
    timeout_fail(name);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(req_ready),   32'h0);
    chk({tag, "_grant"}, 32'(grant_id),    32'h0);
    chk({tag, "_busy"},  32'(busy),        32'h0);
    chk({tag, "_send"},  32'(uart_send),   32'h0);
    chk({tag, "_data"},  32'(uart_data),   32'h0);
    chk({tag, "_terr"},  32'(timeout_err), 32'h0);
  endtask

  initial begin
    vec[0] = '{4'b0100, 32'h00A5_0000, 2, 8'hA5};
    vec[1] = '{4'b1001, 32'h3C00_00C3, 3, 8'h3C};
    vec[2] = '{4'b0001, 32'h0000_0011, 0, 8'h11};
    vec[3] = '{4'b1111, 32'hD4C3_B2A1, 0, 8'hA1};
    vec[4] = '{4'b1111, 32'hD4C3_B2A1, 1, 8'hB2};
    vec[5] = '{4'b1111, 32'hD4C3_B2A1, 2, 8'hC3};
    vec[6] = '{4'b1111, 32'hD4C3_B2A1, 3, 8'hD4};
    vec[7] = '{4'b1111, 32'hD4C3_B2A1, 0, 8'hA1};

    reset = 1'b1; req_valid = '0; req_data = '0;
    uart_tx_active = 1'b0; uart_tx_done = 1'b0;
    tx_st = 0; tx_timer = 0; tx_hold = 0; tx_fast_ok = 0; tx_fast = 0;
    m_ptr = 0; m_phase = 0; m_gap_left = 0; m_elapsed = 0;
    e_ready = '0; e_grant = 0; e_busy = 0; e_send = 0; e_terr = 0; e_data = '0;

    step();
    step();
    chk_reset_values("reset");
    reset = 1'b0;

    // Vector table; a mid-frame reset is inserted before the all-valid run.
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        req_valid = 4'b0010; req_data = 32'h0077_0000;
        wait_ready("rst_grant_wait");
        chk("rst_pre_grant", 32'(grant_id), 32'd1);
        req_valid = '0;
        wait_in_frame("rst_wait_done_wait");
        reset = 1'b1;
        step();
        chk_reset_values("midreset");
        reset = 1'b0;
      end
      req_valid = vec[i].valid;
      req_data  = vec[i].data;
      wait_ready("vec_wait");
      chk("vec_grant", 32'(grant_id),  32'(vec[i].grant));
      chk("vec_data",  32'(uart_data), 32'(vec[i].byte_v));
      chk("vec_ready", 32'(req_ready), 32'(1 << vec[i].grant));
      chk("vec_send",  32'(uart_send), 32'd1);
      req_valid = req_valid & ~req_ready;
      wait_idle("vec_idle");
    end

    // Late request arriving during WAIT_DONE of requester 1.
    req_valid = 4'b0011; req_data = 32'h4433_2211;
    wait_ready("late_first");
    chk("late_grant1", 32'(grant_id), 32'd1);
    req_valid = 4'b0001;
    wait_in_frame("late_frame");
    req_valid = 4'b0101;
    wait_ready("late_second");
    chk("late_grant2", 32'(grant_id),  32'd2);
    chk("late_data2",  32'(uart_data), 32'h33);
    req_valid = req_valid & ~req_ready;
    wait_idle("late_idle2");
    wait_ready("late_third");
    chk("late_grant0", 32'(grant_id), 32'd0);
    req_valid = '0;
    wait_idle("late_idle0");

`ifdef UART_ARB_TIMEOUT_EN
    begin
      int cnt;
      tx_hold = 1;
      req_valid = 4'b0010; req_data = 32'h0000_5A00;
      wait_ready("tmo_grant");
      req_valid = '0;
      cnt = 0;
      for (int c = 0; c < 40 && !timeout_err; c++) begin
        step();
        cnt++;
      end
      chk("timeout_delay", 32'(cnt), 32'(TMO));
      tx_hold = 0;
      wait_idle("tmo_idle");
      req_valid = 4'b0100; req_data = 32'h0066_0000;
      wait_ready("tmo_next");
      chk("tmo_next_grant", 32'(grant_id), 32'd2);
      req_valid = '0;
      wait_idle("tmo_next_idle");
    end
`endif

    // Randomized traffic: each requester holds its queue head until granted.
    tx_fast_ok = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 4 && $urandom_range(0, 5) == 0) q[i].push_back(8'($urandom));
        req_valid[i] = (q[i].size() != 0);
        req_data[i*8 +: 8] = (q[i].size() != 0) ? q[i][0] : 8'($urandom);
      end
      step();
      for (int i = 0; i < N; i++)
        if (e_ready[i] && q[i].size() != 0) void'(q[i].pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
